// File: rtl/led_row_fifo_wr_if.sv
// Row handshake bundle for the LED row FIFO writer.
// Upstream (master) offers row_data/row_idx; the writer (slave) drives row_ready.
interface led_row_fifo_wr_if #(
  parameter int PIX_W = 24,
  parameter int PIX_N = 40,
  parameter int IDX_W = 6
);
  logic                   row_valid;
  logic                   row_ready;
  logic [PIX_W*PIX_N-1:0] row_data;
  logic [IDX_W-1:0]       row_idx;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    output row_ready
  );
endinterface

// File: rtl/led_row_fifo_wr.sv
// LED row FIFO writer: takes a whole row of pixels over a valid/ready
// bundle (row), serializes it LSB-pixel-first into a 24-bit FIFO
// (fifo_full/fifo_wr_en/fifo_din), then idles GAP_CYC cycles so the
// FIFO drains to empty between rows. Status: cur_idx, busy, row_done.
// Clock rd_clk, async active-low reset rst_n.
// Optional macro LED_TEST_PATTERN_EN adds test_mode: rows are replaced
// by the pattern {2'b00, cur_idx, pixel number, 8'h80}.
module led_row_fifo_wr #(
  parameter int PIX_W   = 24,
  parameter int PIX_N   = 40,
  parameter int IDX_W   = 6,
  parameter int GAP_CYC = 4
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  led_row_fifo_wr_if.slave row,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [PIX_W-1:0] fifo_din,
  output logic [IDX_W-1:0] cur_idx,
  output logic             busy,
  output logic             row_done
`ifdef LED_TEST_PATTERN_EN
  ,
  input  logic             test_mode
`endif
);

  localparam int CNT_W = $clog2(PIX_N);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [PIX_W-1:0] shadow [PIX_N];

  logic st_idle;
  logic st_send;
  logic st_gap;
  logic last_pix;
  logic last_gap;

  assign st_idle  = (state == IDLE);
  assign st_send  = (state == SEND);
  assign st_gap   = (state == GAP);
  assign last_pix = (pix_cnt == CNT_W'(PIX_N - 1));
  assign last_gap = (gap_cnt == GAP_W'(GAP_CYC - 1));

  assign row.row_ready = st_idle;
  assign busy          = ~st_idle;
  assign row_done      = st_gap & last_gap;
  // rst_n gate keeps the strobe low from the instant reset asserts
  assign fifo_wr_en    = st_send & ~fifo_full & rst_n;

`ifdef LED_TEST_PATTERN_EN
  logic tm_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_q <= 1'b0;
    end else if (st_idle && row.row_valid) begin
      tm_q <= test_mode;
    end
  end

  always_comb begin
    fifo_din = shadow[pix_cnt];
    if (tm_q) begin
      fifo_din = PIX_W'({2'b00, cur_idx,
                         8'(pix_cnt), 8'h80});
    end
  end
`else
  // Purely registered source: stable while fifo_full stalls
  always_comb begin
    fifo_din = shadow[pix_cnt];
  end
`endif

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pix_cnt <= '0;
      gap_cnt <= '0;
      cur_idx <= '0;
      for (int k = 0; k < PIX_N; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (row.row_valid) begin
            for (int k = 0; k < PIX_N; k++) begin
              shadow[k] <= row.row_data[k*PIX_W +: PIX_W];
            end
            cur_idx <= row.row_idx;
            pix_cnt <= '0;
            state   <= SEND;
          end
        end
        st_send: begin
          if (fifo_wr_en) begin
            if (last_pix) begin
              pix_cnt <= '0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        st_gap: begin
          if (last_gap) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_row_fifo_wr.sv
// Self-checking bench for led_row_fifo_wr: table of row transactions
// with stalls, plus back-to-back, mid-row reset and test-pattern runs.
module tb_led_row_fifo_wr;

  localparam int PIX_W   = 24;
  localparam int PIX_N   = 40;
  localparam int IDX_W   = 6;
  localparam int GAP_CYC = 4;

  logic             rd_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_en;
  logic [PIX_W-1:0] fifo_din;
  logic [IDX_W-1:0] cur_idx;
  logic             busy;
  logic             row_done;
`ifdef LED_TEST_PATTERN_EN
  logic             test_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  led_row_fifo_wr_if #(
    .PIX_W(PIX_W), .PIX_N(PIX_N), .IDX_W(IDX_W)
  ) rif ();

  led_row_fifo_wr #(
    .PIX_W(PIX_W), .PIX_N(PIX_N),
    .IDX_W(IDX_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .row        (rif),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .cur_idx    (cur_idx),
    .busy       (busy),
    .row_done   (row_done)
`ifdef LED_TEST_PATTERN_EN
    ,
    .test_mode  (test_mode)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [PIX_W-1:0] base;
    int               sa;
    int               sal;
    int               sb;
    int               sbl;
    bit               tm;
    int               exp_lat;
    logic [PIX_W-1:0] exp_last;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] exp_pix(
    input bit tm,
    input logic [IDX_W-1:0] idx,
    input logic [PIX_W-1:0] base,
    input int k);
    logic [7:0] kb;
    kb = k[7:0];
    if (tm) return {2'b00, idx, kb, 8'h80};
    return base + PIX_W'(k);
  endfunction

  function automatic logic [PIX_W-1:0] b2b_base(input int r);
    return 24'h200000 + PIX_W'(r * 4096);
  endfunction

  task automatic drive_row(input logic [IDX_W-1:0] idx,
                           input logic [PIX_W-1:0] base);
    for (int k = 0; k < PIX_N; k++) begin
      rif.row_data[k*PIX_W +: PIX_W] = base + PIX_W'(k);
    end
    rif.row_idx = idx;
  endtask

  // Entered and left just after a negedge, DUT in IDLE.
  task automatic run_row(input vec_t v);
    int n, a, b, lat, dones, last_wr, done_cyc, w;
    logic [PIX_W-1:0] last_din;
    n = 0; a = 0; b = 0; lat = 0; dones = 0;
    last_wr = 0; done_cyc = 0; w = 0;
    last_din = '0;
    while (!rif.row_ready && w < 100) begin
      @(negedge rd_clk); #1; w++;
    end
    chk("pre_ready", 32'(rif.row_ready), 1);
    drive_row(v.idx, v.base);
    rif.row_valid = 1'b1;
`ifdef LED_TEST_PATTERN_EN
    test_mode = v.tm;
`endif
    @(posedge rd_clk); #1;
    rif.row_valid = 1'b0;
    rif.row_data  = ~rif.row_data;
    rif.row_idx   = ~v.idx;
`ifdef LED_TEST_PATTERN_EN
    test_mode = ~v.tm;
`endif
    for (int c = 1; c < 200; c++) begin
      @(negedge rd_clk);
      if (n == v.sa && a < v.sal) begin
        fifo_full = 1'b1; a++;
      end else if (n == v.sb && b < v.sbl) begin
        fifo_full = 1'b1; b++;
      end else begin
        fifo_full = 1'b0;
      end
      #1;
      if (fifo_full && busy && n < PIX_N) begin
        chk("stall_wr", 32'(fifo_wr_en), 0);
        chk("stall_din", 32'(fifo_din),
            32'(exp_pix(v.tm, v.idx, v.base, n)));
      end else if (fifo_wr_en) begin
        if (n >= PIX_N) begin
          chk("extra_wr", n, PIX_N - 1);
        end else begin
          chk("wr_din", 32'(fifo_din),
              32'(exp_pix(v.tm, v.idx, v.base, n)));
        end
        last_din = fifo_din;
        n++;
        last_wr = c;
      end
      if (row_done) begin
        dones++;
        done_cyc = c;
      end
      if (rif.row_ready) begin
        lat = c;
        break;
      end
    end
    fifo_full = 1'b0;
    chk("n_writes", n, PIX_N);
    chk("row_done_cnt", dones, 1);
    chk("gap_len", done_cyc - last_wr, GAP_CYC);
    chk("ready_lat", lat, v.exp_lat);
    chk("last_din", 32'(last_din), 32'(v.exp_last));
    chk("cur_idx", 32'(cur_idx), 32'(v.idx));
  endtask

  vec_t vecs [4];
  vec_t rv;

  initial begin
    int n, r, cur, dones, total, last_wr, viol;
    bit pend;

    vecs[0] = '{6'd5, 24'h010000, -1, 0, -1, 0,
                1'b0, 45, 24'h010027};
    vecs[1] = '{6'd9, 24'h0A0000, 10, 3, 39, 1,
                1'b0, 49, 24'h0A0027};
    vecs[2] = '{6'd63, 24'hABC000, 0, 2, -1, 0,
                1'b0, 47, 24'hABC027};
    vecs[3] = '{6'd0, 24'h000100, 39, 5, -1, 0,
                1'b0, 50, 24'h000127};

    rif.row_valid = 1'b0;
    rif.row_data  = '0;
    rif.row_idx   = '0;

    repeat (3) @(negedge rd_clk);
    #1;
    chk("rst_ready", 32'(rif.row_ready), 1);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_din", 32'(fifo_din), 0);
    chk("rst_cur_idx", 32'(cur_idx), 0);
    chk("rst_done", 32'(row_done), 0);
    @(negedge rd_clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 4; i++) begin
      run_row(vecs[i]);
    end

    // Back-to-back rows with row_valid held high
    r = 0; cur = -1; n = 0; dones = 0;
    total = 0; last_wr = 0; viol = 0; pend = 1'b0;
    drive_row(6'd0, b2b_base(0));
    rif.row_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (rif.row_ready === busy) viol++;
      if (fifo_wr_en) begin
        if (n == 0) begin
          chk("b2b_cur_idx", 32'(cur_idx), cur);
          if (cur > 0) begin
            chk("b2b_spacing", c - last_wr, GAP_CYC + 2);
          end
        end
        chk("b2b_din", 32'(fifo_din),
            32'(exp_pix(1'b0, cur[5:0], b2b_base(cur), n)));
        n++;
        total++;
        last_wr = c;
      end
      if (row_done) dones++;
      pend = rif.row_ready && rif.row_valid;
      if (dones == 4 && rif.row_ready) break;
      @(posedge rd_clk); #1;
      if (pend) begin
        cur = r;
        n = 0;
        r++;
        if (r < 4) drive_row(r[5:0], b2b_base(r));
        else rif.row_valid = 1'b0;
      end
      @(negedge rd_clk); #1;
    end
    rif.row_valid = 1'b0;
    chk("b2b_total", total, 4 * PIX_N);
    chk("b2b_dones", dones, 4);
    chk("b2b_rows", r, 4);
    chk("b2b_viol", viol, 0);

    // Reset in the middle of a row
    drive_row(6'd7, 24'h070000);
    rif.row_valid = 1'b1;
    @(posedge rd_clk); #1;
    rif.row_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge rd_clk); #1;
      if (fifo_wr_en) n++;
      if (n == 17) break;
    end
    chk("pre_rst_writes", n, 17);
    rst_n = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(fifo_wr_en), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(rif.row_ready), 1);
    chk("mrst_din", 32'(fifo_din), 0);
    chk("mrst_cur_idx", 32'(cur_idx), 0);
    @(negedge rd_clk);
    rst_n = 1'b1;
    #1;
    rv = '{6'd2, 24'h020000, -1, 0, -1, 0,
           1'b0, 45, 24'h020027};
    run_row(rv);

`ifdef LED_TEST_PATTERN_EN
    rv = '{6'd3, 24'h555555, -1, 0, -1, 0,
           1'b1, 45, 24'h032780};
    run_row(rv);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
